// File: rtl/fwd_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_scoreboard_unit
// Brief    : Operand forwarding select and load-use stall generation for the
//            integer pipeline, with a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_scoreboard_unit #(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 1,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ex_valid,
    input  logic [REG_AW-1:0]           ex_rd,
    input  logic                        ex_regwrite,
    input  logic                        ex_is_load,
    input  logic [NUM_SRC*REG_AW-1:0]   ex_src,
    input  logic                        hold,
    input  logic                        flush_ex,
    output logic [NUM_SRC*SEL_W-1:0]    forward_sel,
    output logic                        stall_req,
    output logic [15:0]                 stall_cycles
);

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    // Tracked producers: entry 0 is EX/MEM, entry DEPTH-1 is just before writeback.
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  load_q,  load_d;
    logic [REG_AW-1:0] rd_q [DEPTH];
    logic [REG_AW-1:0] rd_d [DEPTH];
    logic [15:0]       stall_cycles_q, stall_cycles_d;
    logic [NUM_SRC-1:0] src_stall;
    logic               ex_records;

    generate
        for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
            logic [REG_AW-1:0] src;
            logic [SEL_W-1:0]  sel;
            logic              stall;

            assign src = ex_src[s*REG_AW +: REG_AW];

            // Walk from oldest to youngest so the youngest match overwrites the result;
            // an unready youngest load hides any older ready producer.
            always_comb begin
                sel   = '0;
                stall = 1'b0;
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (valid_q[k] && (rd_q[k] == src) && (src != '0)) begin
                        if (load_q[k] && (k < LOAD_STAGE)) begin
                            sel   = '0;
                            stall = 1'b1;
                        end else begin
                            sel   = SEL_W'(k + 1);
                            stall = 1'b0;
                        end
                    end
                end
            end

            assign forward_sel[s*SEL_W +: SEL_W] = sel;
            assign src_stall[s]                  = stall;
        end
    endgenerate

    assign stall_req  = ex_valid && (|src_stall);
    assign ex_records = ex_valid && ex_regwrite && (ex_rd != '0) && !stall_req && !flush_ex;

    // Shift the producer pipeline and count stall cycles unless frozen by hold.
    always_comb begin
        valid_d        = valid_q;
        load_d         = load_q;
        rd_d           = rd_q;
        stall_cycles_d = stall_cycles_q;
        if (!hold) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                valid_d[k] = valid_q[k-1];
                load_d[k]  = load_q[k-1];
                rd_d[k]    = rd_q[k-1];
            end
            valid_d[0] = ex_records;
            load_d[0]  = ex_is_load;
            rd_d[0]    = ex_rd;
            if (stall_req && (stall_cycles_q != C_CNT_MAX)) begin
                stall_cycles_d = stall_cycles_q + 16'd1;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q        <= '0;
            load_q         <= '0;
            stall_cycles_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rd_q[k] <= '0;
            end
        end else begin
            valid_q        <= valid_d;
            load_q         <= load_d;
            rd_q           <= rd_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_fwd_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_scoreboard_unit
// Brief    : Directed self-checking bench for fwd_scoreboard_unit. Instance A
//            uses defaults, B uses DEPTH=4/LOAD_STAGE=3, C (DEPTH=16,
//            LOAD_STAGE=15) runs a sustained load-use pattern to saturate
//            the stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_scoreboard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_regwrite, ex_is_load, hold, flush_ex;
    logic [4:0]  ex_rd;
    logic [9:0]  ex_src;

    logic [3:0]  fsel_a;
    logic        stall_a;
    logic [15:0] cnt_a;
    logic [5:0]  fsel_b;
    logic        stall_b;
    logic [15:0] cnt_b;

    logic        rst_n_c;
    logic [9:0]  fsel_c;
    logic        stall_c;
    logic [15:0] cnt_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fwd_scoreboard_unit u_a (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .ex_src(ex_src),
        .hold(hold), .flush_ex(flush_ex), .forward_sel(fsel_a),
        .stall_req(stall_a), .stall_cycles(cnt_a)
    );

    fwd_scoreboard_unit #(.DEPTH(4), .LOAD_STAGE(3)) u_b (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .ex_src(ex_src),
        .hold(hold), .flush_ex(flush_ex), .forward_sel(fsel_b),
        .stall_req(stall_b), .stall_cycles(cnt_b)
    );

    // Constant "load x3 that reads x3": one no-stall cycle, then 15 stall cycles, repeating.
    fwd_scoreboard_unit #(.DEPTH(16), .LOAD_STAGE(15)) u_c (
        .clk(clk), .rst_n(rst_n_c), .ex_valid(1'b1), .ex_rd(5'd3),
        .ex_regwrite(1'b1), .ex_is_load(1'b1), .ex_src({5'd0, 5'd3}),
        .hold(1'b0), .flush_ex(1'b0), .forward_sel(fsel_c),
        .stall_req(stall_c), .stall_cycles(cnt_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic [4:0] rd, input logic wr,
                          input logic ld, input logic [4:0] s0, input logic [4:0] s1);
        ex_valid    = v;
        ex_rd       = rd;
        ex_regwrite = wr;
        ex_is_load  = ld;
        ex_src      = {s1, s0};
    endtask

    // Move to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        rst_n_c = 1'b0;
        hold    = 1'b0;
        flush_ex = 1'b0;
        set_ex(1'b1, 5'd3, 1'b1, 1'b1, 5'd3, 5'd3);
        #12;
        check("reset_fsel", fsel_a, 4'h0);
        check("reset_stall", stall_a, 1'b0);
        check("reset_cnt", cnt_a, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back ALU dependency.
        set_ex(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2);
        #1;
        check("alu_first_nostall", stall_a, 1'b0);
        step();
        set_ex(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd0);
        #1;
        check("alu_b2b_fsel", fsel_a, 4'b0001);
        check("alu_b2b_stall", stall_a, 1'b0);
        step();

        // Two producers of x7: youngest (entry 0) wins.
        set_ex(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0);
        step();
        step();
        set_ex(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 5'd7);
        #1;
        check("youngest_x7", fsel_a, 4'b0100);
        set_ex(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 5'd0);
        #1;
        check("x0_nomatch", fsel_a, 4'b0000);
        step();
        // Entries now x8 (0) and x7 (1): sources resolve independently.
        set_ex(1'b1, 5'd1, 1'b0, 1'b0, 5'd7, 5'd8);
        #1;
        check("indep_srcs", fsel_a, 4'b0110);
        step();
        step();
        check("dropped_producer", fsel_a, 4'b0000);

        // Load-use with defaults.
        set_ex(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0);
        #1;
        check("load_nostall", stall_a, 1'b0);
        step();
        set_ex(1'b1, 5'd4, 1'b1, 1'b0, 5'd3, 5'd0);
        #1;
        check("lu_stall", stall_a, 1'b1);
        check("lu_stall_fsel", fsel_a, 4'b0000);
        check("lu_cnt0", cnt_a, 16'd0);
        step();
        check("lu_cnt1", cnt_a, 16'd1);
        check("lu_release", stall_a, 1'b0);
        check("lu_fsel2", fsel_a, 4'b0010);
        step();

        // Load-use under hold: frozen for 4 cycles.
        set_ex(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0);
        step();
        set_ex(1'b1, 5'd4, 1'b1, 1'b0, 5'd3, 5'd0);
        #1;
        check("hold_pre_stall", stall_a, 1'b1);
        ex_valid = 1'b0;
        #1;
        check("invalid_ex_nostall", stall_a, 1'b0);
        ex_valid = 1'b1;
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("hold_stall", stall_a, 1'b1);
            check("hold_cnt", cnt_a, 16'd1);
        end
        hold = 1'b0;
        step();
        check("hold_cnt_after", cnt_a, 16'd2);
        check("hold_fsel_after", fsel_a, 4'b0010);
        step();

        // Flushed writer is not recorded; neither is a non-writer.
        set_ex(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0);
        flush_ex = 1'b1;
        step();
        flush_ex = 1'b0;
        set_ex(1'b1, 5'd11, 1'b0, 1'b0, 5'd9, 5'd0);
        #1;
        check("flush_fsel", fsel_a, 4'b0000);
        step();
        set_ex(1'b1, 5'd1, 1'b0, 1'b0, 5'd11, 5'd0);
        #1;
        check("noregwrite_fsel", fsel_a, 4'b0000);
        step();

        // Flush during a stall: a single bubble, count +1.
        set_ex(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0);
        step();
        set_ex(1'b1, 5'd4, 1'b1, 1'b0, 5'd3, 5'd0);
        flush_ex = 1'b1;
        #1;
        check("flush_stall", stall_a, 1'b1);
        step();
        flush_ex = 1'b0;
        check("flush_stall_cnt", cnt_a, 16'd3);
        check("flush_stall_fsel", fsel_a, 4'b0010);
        step();

        // Asynchronous reset mid-stall.
        set_ex(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0);
        step();
        set_ex(1'b1, 5'd4, 1'b1, 1'b0, 5'd3, 5'd0);
        #1;
        check("pre_rst_stall", stall_a, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_stall", stall_a, 1'b0);
        check("rst_mid_cnt", cnt_a, 16'd0);
        #1;
        rst_n = 1'b1;

        // Deeper configuration: 3-cycle stall, then forward from entry 3.
        set_ex(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        step();
        step();
        step();
        step();
        set_ex(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0);
        step();
        set_ex(1'b1, 5'd4, 1'b1, 1'b0, 5'd3, 5'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("deep_stall", stall_b, 1'b1);
            check("deep_cnt", cnt_b, 32'(i));
            step();
        end
        check("deep_release", stall_b, 1'b0);
        check("deep_fsel4", fsel_b, 6'b000100);
        check("deep_cnt3", cnt_b, 16'd3);
        set_ex(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);

        // Saturation: 15 stalls every 16 edges.
        @(negedge clk);
        rst_n_c = 1'b1;
        repeat (32) @(posedge clk);
        #1;
        check("sat_cnt30", cnt_c, 16'd30);
        check("sat_gap_nostall", stall_c, 1'b0);
        @(posedge clk);
        #1;
        check("sat_stalling", stall_c, 1'b1);
        repeat (69904 - 33) @(posedge clk);
        #1;
        check("sat_reach_max", cnt_c, 16'hFFFF);
        repeat (16) @(posedge clk);
        #1;
        check("sat_hold_max", cnt_c, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
